patch_arbiter: RTL and testbench

- Shares the single sorter application input between N_SRC patch sources, each a first-word-fall-through FIFO read port (val/ack, consume on ack).
- Selects sources round-robin, screens each patch against the sorter's current sync window and drops out-of-window patches, and presents accepted patches through a one-entry output register.
- Sits between the per-link Aurora FIFOs and the sorter application, in the sorter clock domain.

---
 rtl/patch_arbiter.sv | 140 ++++++++++++++
 tb/tb_patch_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_arbiter.sv
// Round-robin arbiter that feeds the sorter from N_SRC patch FIFOs, dropping patches outside the sync window.
// Optional per-source grant counters are built when PATCH_ARBITER_GRANT_STATS_EN is defined.
module patch_arbiter #(
  parameter int DELAY       = 3,
  parameter int N_SRC       = 2,
  parameter int N_PATCH     = 600000,
  parameter int SYNC_WINDOW = 8192,
  parameter int FP_SIZE     = 20,
  parameter int PN_W        = $clog2(N_PATCH)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  input  logic [PN_W-1:0]          win_base,
  input  logic [N_SRC-1:0]         src_val,
  input  logic [N_SRC*PN_W-1:0]    src_num,
  input  logic [N_SRC*FP_SIZE-1:0] src_wtsum,
  output logic [N_SRC-1:0]         src_ack,
  output logic                     patch_val,
  output logic [PN_W-1:0]          patch_num,
  output logic [FP_SIZE-1:0]       patch_wtsum,
  input  logic                     patch_ack,
  output logic                     drop_pulse,
  output logic [15:0]              drop_cnt,
  output logic [N_SRC*32-1:0]      grant_cnt,
  output logic [1:0]               dbg_state
);

  // Handshake: src_ack[i] is a combinational read strobe; the FIFO pops the word it shows on src_num/src_wtsum
  // in that cycle. patch_ack consumes the held patch only while patch_val is high.

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [SW-1:0]       rr_ptr;
  logic [SW-1:0]       g_idx;
  logic                cand_hit;
  logic                slot_free;
  logic                grant;
  logic                accept;
  logic [PN_W-1:0]     sel_num;
  logic [FP_SIZE-1:0]  sel_wtsum;
  logic [PN_W:0]       n_ext, base_ext, lim_ext;
  logic                unused_delay;

  // DELAY only shaped register timing in behavioural models; it has no effect here.
  assign unused_delay = (DELAY != 0);

  assign slot_free = !patch_val || patch_ack;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // First requesting source strictly after rr_ptr, wrapping.
  always_comb begin
    int idx;
    cand_hit = 1'b0;
    g_idx    = rr_ptr;
    idx      = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!cand_hit && src_val[idx]) begin
        cand_hit = 1'b1;
        g_idx    = SW'(idx);
      end
    end
  end

  assign grant     = (state == S_RUN) && slot_free && cand_hit;
  assign src_ack   = grant ? (N_SRC'(1) << g_idx) : '0;
  assign sel_num   = src_num[g_idx*PN_W +: PN_W];
  assign sel_wtsum = src_wtsum[g_idx*FP_SIZE +: FP_SIZE];

  // One extra bit so win_base+SYNC_WINDOW never wraps.
  assign n_ext    = {1'b0, sel_num};
  assign base_ext = {1'b0, win_base};
  assign lim_ext  = base_ext + (PN_W+1)'(SYNC_WINDOW);
  assign accept   = (n_ext >= base_ext) && (n_ext < lim_ext) && (n_ext < (PN_W+1)'(N_PATCH));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !stop) state_nxt = S_RUN;
      S_RUN:   if (stop) state_nxt = S_DRAIN;
      S_DRAIN: if (!patch_val || patch_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      rr_ptr      <= SW'(N_SRC-1);
      patch_val   <= 1'b0;
      patch_num   <= '0;
      patch_wtsum <= '0;
      drop_pulse  <= 1'b0;
      drop_cnt    <= 16'd0;
    end else begin
      state <= state_nxt;
      if (grant) rr_ptr <= g_idx;
      if (grant && accept) begin
        patch_val   <= 1'b1;
        patch_num   <= sel_num;
        patch_wtsum <= sel_wtsum;
      end else if (patch_ack) begin
        patch_val <= 1'b0;
      end
      drop_pulse <= grant && !accept;
      if (grant && !accept && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef PATCH_ARBITER_GRANT_STATS_EN
  logic [31:0] gcnt_q [N_SRC];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < N_SRC; i++) gcnt_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < N_SRC; i++) if (src_ack[i]) gcnt_q[i] <= gcnt_q[i] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_gcnt
    assign grant_cnt[gi*32 +: 32] = gcnt_q[gi];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_patch_arbiter.sv
// Directed self-checking bench for patch_arbiter: round-robin order, backpressure, window drops, drain and reset.
// With PATCH_ARBITER_GRANT_STATS_EN a second 3-source instance checks the grant counters.
module tb_patch_arbiter;

  localparam int N_SRC   = 2;
  localparam int FP_SIZE = 20;
  localparam int PN_W    = 20;

  logic                     CLK;
  logic                     RESET;
  logic                     start, stop;
  logic                     busy;
  logic [PN_W-1:0]          win_base;
  logic [N_SRC-1:0]         src_val;
  logic [N_SRC*PN_W-1:0]    src_num;
  logic [N_SRC*FP_SIZE-1:0] src_wtsum;
  logic [N_SRC-1:0]         src_ack;
  logic                     patch_val;
  logic [PN_W-1:0]          patch_num;
  logic [FP_SIZE-1:0]       patch_wtsum;
  logic                     patch_ack;
  logic                     drop_pulse;
  logic [15:0]              drop_cnt;
  logic [N_SRC*32-1:0]      grant_cnt;
  logic [1:0]               dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [PN_W-1:0] exp_q[$];

  patch_arbiter u_dut (
    .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .busy(busy),
    .win_base(win_base), .src_val(src_val), .src_num(src_num), .src_wtsum(src_wtsum),
    .src_ack(src_ack), .patch_val(patch_val), .patch_num(patch_num), .patch_wtsum(patch_wtsum),
    .patch_ack(patch_ack), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt),
    .grant_cnt(grant_cnt), .dbg_state(dbg_state)
  );

`ifdef PATCH_ARBITER_GRANT_STATS_EN
  logic              start3;
  logic              busy3;
  logic [2:0]        src_val3;
  logic [3*PN_W-1:0] src_num3;
  logic [3*FP_SIZE-1:0] src_wtsum3;
  logic [2:0]        src_ack3;
  logic              patch_val3;
  logic [PN_W-1:0]   patch_num3;
  logic [FP_SIZE-1:0] patch_wtsum3;
  logic              drop_pulse3;
  logic [15:0]       drop_cnt3;
  logic [3*32-1:0]   grant_cnt3;
  logic [1:0]        dbg_state3;

  patch_arbiter #(.N_SRC(3)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .start(start3), .stop(1'b0), .busy(busy3),
    .win_base('0), .src_val(src_val3), .src_num(src_num3), .src_wtsum(src_wtsum3),
    .src_ack(src_ack3), .patch_val(patch_val3), .patch_num(patch_num3), .patch_wtsum(patch_wtsum3),
    .patch_ack(1'b1), .drop_pulse(drop_pulse3), .drop_cnt(drop_cnt3),
    .grant_cnt(grant_cnt3), .dbg_state(dbg_state3)
  );
`endif

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_src(input int i, input logic [PN_W-1:0] n);
    src_num[i*PN_W +: PN_W]      = n;
    src_wtsum[i*FP_SIZE +: FP_SIZE] = FP_SIZE'(n) + FP_SIZE'(7);
  endtask

  initial begin
    int c0, c1;
    logic [N_SRC-1:0] a;
    logic [PN_W-1:0] nums [5];
    logic exp_drop [5];
    logic exp_val [5];
    logic [PN_W-1:0] exp_num [5];
    logic [15:0] exp_cnt [5];

    RESET = 1'b0; start = 0; stop = 0; win_base = '0; src_val = '0;
    src_num = '0; src_wtsum = '0; patch_ack = 0;
`ifdef PATCH_ARBITER_GRANT_STATS_EN
    start3 = 0; src_val3 = '0; src_num3 = '0; src_wtsum3 = '0;
`endif
    #3;
    check_eq("rst_patch_val", patch_val, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_src_ack", src_ack, 0);
    check_eq("rst_grant_cnt", grant_cnt, 0);
    check_eq("rst_state", dbg_state, 0);
    #14 RESET = 1'b1;
    tick();

    // Test 1: both sources streaming, full throughput
    for (int k = 0; k < 100; k++) exp_q.push_back(PN_W'(k));
    c0 = 0; c1 = 0;
    src_val = 2'b11; patch_ack = 1; start = 1;
    set_src(0, 0); set_src(1, 1);
    #1 check_eq("idle_no_ack", src_ack, 0);
    tick();
    start = 0;
    for (int k = 0; k < 100; k++) begin
      set_src(0, PN_W'(2*c0)); set_src(1, PN_W'(2*c1+1));
      #1 check_eq("rr_ack", src_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
      a = src_ack;
      tick();
      if (a[0]) c0++;
      if (a[1]) c1++;
      check_eq("rr_val", patch_val, 1);
      check_eq("rr_num", patch_num, exp_q.pop_front());
      check_eq("rr_wtsum", patch_wtsum, k + 7);
    end

    // Test 2: source 1 only, backpressure
    src_val = 2'b10; set_src(1, 500);
    #1 check_eq("bp_first_ack", src_ack, 2'b10);
    tick();
    check_eq("bp_first_num", patch_num, 500);
    patch_ack = 0; set_src(1, 501);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("bp_hold_ack", src_ack, 0);
      tick();
      check_eq("bp_hold_val", patch_val, 1);
      check_eq("bp_hold_num", patch_num, 500);
    end
    patch_ack = 1;
    #1 check_eq("bp_release_ack", src_ack, 2'b10);
    tick();
    check_eq("bp_next_val", patch_val, 1);
    check_eq("bp_next_num", patch_num, 501);
    src_val = 2'b00;
    #1 check_eq("bp_empty_ack", src_ack, 0);
    tick();
    check_eq("bp_drained_val", patch_val, 0);
    check_eq("bp_num_hold", patch_num, 501);

    // Test 3: window screening, win_base=1000
    win_base = 1000; src_val = 2'b01;
    nums = '{999, 1000, 9191, 9192, 600000};
    exp_drop = '{1, 0, 0, 1, 1};
    exp_val  = '{0, 1, 1, 0, 0};
    exp_num  = '{501, 1000, 9191, 9191, 9191};
    exp_cnt  = '{1, 1, 1, 2, 3};
    for (int k = 0; k < 5; k++) begin
      set_src(0, nums[k]);
      #1 check_eq("win_ack", src_ack, 2'b01);
      tick();
      check_eq("win_drop_pulse", drop_pulse, exp_drop[k]);
      check_eq("win_val", patch_val, exp_val[k]);
      check_eq("win_num", patch_num, exp_num[k]);
      check_eq("win_drop_cnt", drop_cnt, exp_cnt[k]);
    end
    src_val = 2'b00;
    tick();
    check_eq("win_pulse_clear", drop_pulse, 0);
    check_eq("win_drop_cnt_final", drop_cnt, 3);

    // Test 4: stop while the output is held
    patch_ack = 0; src_val = 2'b01; set_src(0, 2000);
    #1 check_eq("drain_load_ack", src_ack, 2'b01);
    tick();
    check_eq("drain_load_num", patch_num, 2000);
    stop = 1;
    #1 check_eq("drain_stop_ack", src_ack, 0);
    tick();
    stop = 0;
    for (int k = 0; k < 5; k++) begin
      #1 check_eq("drain_ack", src_ack, 0);
      check_eq("drain_busy", busy, 1);
      check_eq("drain_state", dbg_state, 2);
      tick();
    end
    patch_ack = 1;
    #1 check_eq("drain_final_ack", src_ack, 0);
    tick();
    check_eq("drain_idle_busy", busy, 0);
    check_eq("drain_idle_val", patch_val, 0);
    check_eq("drain_idle_state", dbg_state, 0);
    check_eq("drain_idle_ack", src_ack, 0);

    // start+stop together and stop alone are ignored in IDLE
    start = 1; stop = 1;
    tick();
    check_eq("idle_start_stop", busy, 0);
    start = 0;
    tick();
    check_eq("idle_stop", busy, 0);
    stop = 0;

    // Test 5: async reset mid-stream
    set_src(0, 1000); set_src(1, 1001); src_val = 2'b11; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    check_eq("mid_val", patch_val, 1);
    check_eq("mid_drop_cnt", drop_cnt, 3);
    #1 RESET = 1'b0;
    #1;
    check_eq("arst_val", patch_val, 0);
    check_eq("arst_ack", src_ack, 0);
    check_eq("arst_drop_cnt", drop_cnt, 0);
    check_eq("arst_busy", busy, 0);
    #3 RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("post_rst_ack", src_ack, 0);
      check_eq("post_rst_val", patch_val, 0);
    end
    start = 1;
    #1 check_eq("post_rst_start_ack", src_ack, 0);
    tick();
    start = 0;
    #1 check_eq("post_rst_first_grant", src_ack, 2'b01);

`ifdef PATCH_ARBITER_GRANT_STATS_EN
    // Test 6: grant counters on three sources, drops included
    src_val = 2'b00;
    src_num3   = {PN_W'(20000), PN_W'(10), PN_W'(700000)};
    src_wtsum3 = '0;
    src_val3   = 3'b111;
    start3     = 1;
    tick();
    start3 = 0;
    for (int k = 0; k < 30; k++) tick();
    src_val3 = 3'b000;
    tick();
    check_eq("gcnt_src0", grant_cnt3[0 +: 32], 10);
    check_eq("gcnt_src1", grant_cnt3[32 +: 32], 10);
    check_eq("gcnt_src2", grant_cnt3[64 +: 32], 10);
    check_eq("gcnt_drops", drop_cnt3, 20);
`else
    tick();
    check_eq("gcnt_disabled", grant_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
